prbs_checker: RTL

- Receive-side companion to the byte-wide pattern/PRBS-15 stream generator.
- Learns a 32-bit pattern from the first 4 valid bytes after reset.
- Checks n_pattern repetitions of that pattern, then checks an indefinite PRBS-15 byte stream against a local LFSR.
- Reports byte and bit error counts, lock status and phase.
- Sits at the loopback/receive end of the link test path.

---
 rtl/prbs_checker.sv | 130 +++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// Receive-side pattern/PRBS-15 checker: learns a 32-bit pattern, verifies its repetitions,
// then tracks a PRBS-15 byte stream against a local LFSR with saturating error counters.
module prbs_checker #(
  parameter logic [14:0] SEED       = 15'h7757,
  parameter int          BYTE_CNT_W = 16,
  parameter int          BIT_CNT_W  = 24
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            IN,
  input  logic                  in_valid,
  input  logic [7:0]            n_pattern,
  input  logic                  clr_cnt,
  output logic [31:0]           pattern_out,
  output logic [1:0]            state,
  output logic                  err_flag,
  output logic [BYTE_CNT_W-1:0] byte_err_cnt,
  output logic [BIT_CNT_W-1:0]  bit_err_cnt,
  output logic                  locked
);

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    LEARN      = 2'b01,
    CHECK_PAT  = 2'b10,
    CHECK_PRBS = 2'b11
  } state_t;

  state_t         cur_state, next_state;
  logic [1:0]     idx;
  logic [7:0]     rep;
  logic [14:0]    lfsr;
  logic [2:0]     good_cnt;
  logic           fb;
  logic [7:0]     expected;
  logic [7:0]     diff;
  logic [3:0]     pop;
  logic           check_en;
  logic           mismatch;
  logic [BIT_CNT_W:0] bit_sum;

  assign state  = cur_state;
  assign locked = (good_cnt == 3'd4);
  assign fb     = lfsr[14] ^ lfsr[13];

  always_comb begin
    expected = {fb, lfsr[6:0]};
    if (cur_state == CHECK_PAT)
      expected = pattern_out[{idx, 3'b000} +: 8];
    check_en = in_valid && (cur_state == CHECK_PAT || cur_state == CHECK_PRBS);
    diff     = IN ^ expected;
    mismatch = check_en && (diff != 8'h00);
    pop      = 4'd0;
    for (int i = 0; i < 8; i++)
      pop = pop + {3'b000, diff[i]};
    bit_sum  = {1'b0, bit_err_cnt} + {{(BIT_CNT_W - 3){1'b0}}, pop};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      cur_state <= IDLE;
    else
      cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    case (cur_state)
      IDLE:       next_state = LEARN;
      LEARN:
        if (in_valid && idx == 2'd3)
          next_state = (n_pattern != 8'd0) ? CHECK_PAT : CHECK_PRBS;
      CHECK_PAT:
        if (in_valid && idx == 2'd3 && rep == 8'd1)
          next_state = CHECK_PRBS;
      CHECK_PRBS: next_state = CHECK_PRBS;
      default:    next_state = IDLE;
    endcase
  end

  // Datapath: pattern capture, repetition tracking, LFSR, lock and error statistics.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pattern_out  <= '0;
      idx          <= '0;
      rep          <= '0;
      lfsr         <= SEED;
      good_cnt     <= '0;
      err_flag     <= 1'b0;
      byte_err_cnt <= '0;
      bit_err_cnt  <= '0;
    end else begin
      if (cur_state == LEARN && in_valid) begin
        pattern_out[{idx, 3'b000} +: 8] <= IN;
        idx <= idx + 2'd1;
        if (idx == 2'd3)
          rep <= n_pattern;
      end

      if (cur_state == CHECK_PAT && in_valid) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3)
          rep <= rep - 8'd1;
      end

      if (cur_state == CHECK_PRBS && in_valid) begin
        lfsr <= {lfsr[13:0], fb};
        if (mismatch)
          good_cnt <= '0;
        else if (good_cnt != 3'd4)
          good_cnt <= good_cnt + 3'd1;
      end

      // A clear wins over a coincident error, so that byte's error is discarded.
      if (clr_cnt) begin
        err_flag     <= 1'b0;
        byte_err_cnt <= '0;
        bit_err_cnt  <= '0;
      end else begin
        err_flag <= mismatch;
        if (mismatch) begin
          if (byte_err_cnt != '1)
            byte_err_cnt <= byte_err_cnt + 1'b1;
          bit_err_cnt <= bit_sum[BIT_CNT_W] ? '1 : bit_sum[BIT_CNT_W-1:0];
        end
      end
    end
  end

endmodule
